// File: rtl/data_cache_ctrl_pkg.sv
// rtl/data_cache_ctrl_pkg.sv - shared widths, sizes and FSM state type for the data cache
package data_cache_ctrl_pkg;

    localparam int TAG_W  = 3;
    localparam int IDX_W  = 5;
    localparam int OFF_W  = 2;
    localparam int LINE_W = 128;
    localparam int LINES  = 32;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        WDONE
    } state_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - direct-mapped data/tag/valid storage with line fill and word write
module dcache_array
    import data_cache_ctrl_pkg::*;
#(
    parameter int N_LINES = LINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx,
    input  logic [OFF_W-1:0]  off,
    output logic [WORD_W-1:0] rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic              line_we,
    input  logic [LINE_W-1:0] line_wdata,
    input  logic [TAG_W-1:0]  tag_wdata,
    input  logic              word_we,
    input  logic [WORD_W-1:0] word_wdata
);

    logic [LINE_W-1:0] data_mem [N_LINES];
    logic [TAG_W-1:0]  tag_mem  [N_LINES];
    logic [N_LINES-1:0] valid;

    assign rd_word  = data_mem[idx][{off, 5'b0} +: WORD_W];
    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid[idx];

    // Only the valid bits are reset; stale data/tags are harmless behind a clear valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
        end else if (line_we) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[idx] <= line_wdata;
            tag_mem[idx]  <= tag_wdata;
        end else if (word_we) begin
            data_mem[idx][{off, 5'b0} +: WORD_W] <= word_wdata;
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - write-through, no-write-allocate direct-mapped data cache controller
module data_cache_ctrl #(
    parameter int LINES = data_cache_ctrl_pkg::LINES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_re,
    input  logic         cpu_we,
    input  logic [9:0]   cpu_addrs,
    input  logic [31:0]  cpu_wd,
    output logic [31:0]  cpu_rd,
    output logic         stall,
    output logic         dm_re,
    output logic         dm_we,
    output logic [9:0]   dm_addrs,
    output logic [31:0]  dm_wd,
    input  logic [127:0] dm_rd_2cache,
    input  logic         ready
);

    import data_cache_ctrl_pkg::*;

    state_t            state;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              hit;
    logic              line_we;
    logic              word_we;

    assign tag = cpu_addrs[9:7];
    assign idx = cpu_addrs[6:2];
    assign off = cpu_addrs[1:0];
    assign hit = rd_valid && (rd_tag == tag);

    // Array writes are gated by reset so an aborted transfer never lands.
    assign line_we = reset && (state == FILL) && ready;
    assign word_we = reset && (state == WRITE) && ready && hit;

    dcache_array #(
        .N_LINES (LINES)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .idx        (idx),
        .off        (off),
        .rd_word    (cpu_rd),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .line_we    (line_we),
        .line_wdata (dm_rd_2cache),
        .tag_wdata  (tag),
        .word_we    (word_we),
        .word_wdata (cpu_wd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (cpu_we) state <= WRITE;
                         else if (cpu_re && !hit) state <= FILL;
                FILL:    if (ready) state <= IDLE;
                WRITE:   if (ready) state <= WDONE;
                WDONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        dm_addrs = '0;
        dm_wd    = '0;
        if (reset) begin
            case (state)
                IDLE:  stall = cpu_we || (cpu_re && !hit);
                FILL:  begin
                    stall    = 1'b1;
                    dm_re    = 1'b1;
                    dm_addrs = {cpu_addrs[9:2], 2'b00};
                end
                WRITE: begin
                    stall    = 1'b1;
                    dm_we    = 1'b1;
                    dm_addrs = cpu_addrs;
                    dm_wd    = cpu_wd;
                end
                default: stall = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 The block SHALL have parameter LINES, default 32, giving the number of direct-mapped cache lines; each line holds 4 x 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port cpu_re, input, 1 bit: CPU load request.
REQ-005 The block SHALL have port cpu_we, input, 1 bit: CPU store request.
REQ-006 The block SHALL have port cpu_addrs, input, 10 bits: word address; [1:0] is the offset, [6:2] the index, [9:7] the tag.
REQ-007 The block SHALL have port cpu_wd, input, 32 bits: store data.
REQ-008 The block SHALL have port cpu_rd, output, 32 bits: load data.
REQ-009 The block SHALL have port stall, output, 1 bit: CPU freeze; the CPU holds its request and operands while stall is high.
REQ-010 The block SHALL have port dm_re, output, 1 bit: memory line-read request.
REQ-011 The block SHALL have port dm_we, output, 1 bit: memory word-write request.
REQ-012 The block SHALL have port dm_addrs, output, 10 bits: memory word address.
REQ-013 The block SHALL have port dm_wd, output, 32 bits: memory write data.
REQ-014 The block SHALL have port dm_rd_2cache, input, 128 bits: line from memory; word n is at bits [32n+31:32n].
REQ-015 The block SHALL have port ready, input, 1 bit: memory completion; it rises after the request has been held for 3 rising edges.

Function
REQ-016 The FSM SHALL have the states IDLE, FILL, WRITE and WDONE.
REQ-017 Hit SHALL be defined as valid[index] && tag_array[index]==cpu_addrs[9:7].
REQ-018 In IDLE, a read hit with cpu_re=1 and cpu_we=0 SHALL give cpu_rd = the offset word of the line, combinationally, with stall=0 and zero-cycle latency.
REQ-019 In IDLE, a read miss SHALL drive stall=1 combinationally, and the FSM SHALL go to FILL on the next edge.
REQ-020 In IDLE, cpu_we=1 SHALL drive stall=1, and the FSM SHALL go to WRITE; cpu_we SHALL take priority when cpu_re and cpu_we are both high.
REQ-021 In FILL, the block SHALL drive dm_re=1, dm_addrs={cpu_addrs[9:2],2'b00}, stall=1.
REQ-022 In FILL, on the edge where ready=1, the block SHALL load dm_rd_2cache into the data line, set tag and valid, and return to IDLE, where the held request then hits.
REQ-023 In WRITE, the block SHALL drive dm_we=1, dm_addrs=cpu_addrs, dm_wd=cpu_wd, stall=1.
REQ-024 On the WRITE edge with ready=1, if the address hits, the block SHALL update that cached word with cpu_wd; the FSM SHALL go to WDONE.
REQ-025 Stores SHALL be write-through and no-write-allocate: a store miss SHALL leave the cache array untouched.
REQ-026 WDONE SHALL last exactly one cycle with stall=0 and dm_re=dm_we=0, so the retiring store is not re-issued; the FSM SHALL then go to IDLE.
REQ-027 dm_re and dm_we SHALL be decoded from state only, held stable until ready is sampled, and never asserted together.
REQ-028 With no request in IDLE, outputs SHALL be stall=0, dm_re=0, dm_we=0; cpu_rd SHALL be don't-care.
REQ-029 ready seen in IDLE or WDONE SHALL be ignored.
REQ-030 With the 3-count memory, a read miss and a store SHALL each stall for exactly 5 cycles.

Reset
REQ-031 When reset=0 at a rising edge, the FSM SHALL go to IDLE and all valid bits SHALL clear; the data and tag arrays SHALL not be reset.
REQ-032 While reset=0, outputs SHALL be stall=0, dm_re=0, dm_we=0, dm_addrs=0, dm_wd=0.
REQ-033 Reset in FILL or WRITE SHALL abort the transfer; a partial fill SHALL never set valid.

Structure
REQ-034 A shared package SHALL hold the state enum, TAG_W=3, IDX_W=5, OFF_W=2, LINE_W=128 and LINES.
REQ-035 Storage SHALL be one sub-module, dcache_array (data, tag and valid arrays, line write plus word write, combinational read); the FSM and datapath stay in data_cache_ctrl.

Verification
REQ-036 Scenario, reset then cold read: reset low for 2 cycles, then cpu_re at 0x004 -> stall high 5 cycles, dm_re with dm_addrs=0x004, line filled; cpu_rd = mem[0x004] in cycle 6.
REQ-037 Scenario, hit after fill: cpu_re at 0x005, 0x006, 0x007 on back-to-back cycles -> stall=0 and correct words every cycle, dm_re never asserted.
REQ-038 Scenario, store hit: cpu_we at 0x005 with data 0xDEADBEEF -> dm_we with dm_wd=0xDEADBEEF; WDONE with stall=0 once; a following read of 0x005 hits and returns 0xDEADBEEF.
REQ-039 Scenario, store miss: cpu_we at 0x3F0 -> memory written, valid[28] still 0; a read of 0x3F0 misses and fills.
REQ-040 Scenario, conflict: read 0x004, then read 0x084 (same index, tag 1) -> second read misses and refills; re-read 0x004 misses again.
REQ-041 Scenario, reset mid-operation: reset=0 in the second FILL cycle -> next cycle dm_re=0, stall=0, and the address re-misses afterwards.
